// File: rtl/prbs_block_ctrl.sv
// Frame/block sequencer for the PRBS randomizer: seed-load pulse per block, bit gating, progress and done reporting.
// Bit transfers are combinational (src_ready = prbs_ready & fec_ready in RUN); define PRBS_STALL_TIMEOUT_EN for the stall watchdog.
module prbs_block_ctrl #(
  parameter int BLOCK_BITS = 96,
  parameter int NBLK_W     = 8
`ifdef PRBS_STALL_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NBLK_W-1:0]             num_blocks,
  input  logic                          abort,
  input  logic                          src_valid,
  output logic                          src_ready,
  output logic                          prbs_load,
  output logic                          prbs_en,
  output logic                          prbs_valid,
  input  logic                          prbs_ready,
  input  logic                          fec_ready,
  output logic                          busy,
  output logic                          block_start,
  output logic                          block_end,
  output logic                          done,
  output logic [$clog2(BLOCK_BITS)-1:0] bit_cnt,
  output logic [NBLK_W-1:0]             blk_cnt,
  output logic                          err
);

  localparam int BIT_W = $clog2(BLOCK_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BLOCK_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [NBLK_W-1:0] num_lat;
  logic [NBLK_W-1:0] blk_inc;
  logic              xfer;
  logic              last_bit;
  logic              last_blk;
  logic              start_ok;
  logic              stall_to;

  assign src_ready   = (state == RUN) & prbs_ready & fec_ready;
  assign xfer        = src_valid & src_ready;
  assign prbs_en     = xfer;
  assign prbs_valid  = xfer;
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign blk_inc     = blk_cnt + 1'b1;
  assign last_blk    = (blk_inc == num_lat);
  assign block_start = xfer & (bit_cnt == '0);
  assign block_end   = xfer & last_bit;
  assign start_ok    = start & ~abort & (num_blocks != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prbs_load = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = LOAD;
      end
      LOAD: begin
        prbs_load = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (xfer && last_bit) state_nxt = last_blk ? DONE : LOAD;
        else if (stall_to)    state_nxt = IDLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // An in-flight transfer still completes this cycle; only the next state is overridden.
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      blk_cnt <= '0;
      num_lat <= '0;
    end else if (state == IDLE) begin
      // blk_cnt keeps the last frame's count until a new frame is accepted.
      if (start_ok) begin
        num_lat <= num_blocks;
        blk_cnt <= '0;
        bit_cnt <= '0;
      end
    end else if (abort || stall_to) begin
      bit_cnt <= '0;
      blk_cnt <= '0;
    end else if (state == LOAD) begin
      bit_cnt <= '0;
    end else if (xfer) begin
      if (last_bit) begin
        bit_cnt <= '0;
        blk_cnt <= blk_inc;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef PRBS_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt;

  // Held at zero outside RUN, so every entry into RUN starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset || (state != RUN) || xfer || stall_to) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_to = (state == RUN) & ~xfer & (stall_cnt == STALL_LAST);
`else
  assign stall_to = 1'b0;
`endif

  assign err = stall_to;

endmodule

// File: tb/tb_prbs_block_ctrl.sv
// Bench for prbs_block_ctrl: transfer scoreboard plus a backpressure vector table and hand-written frame sequences.
module tb_prbs_block_ctrl;
  localparam int BB = 96;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset, start, abort, src_valid, prbs_ready, fec_ready;
  logic [NW-1:0] num_blocks;
  logic          src_ready, prbs_load, prbs_en, prbs_valid, busy;
  logic          block_start, block_end, done, err;
  logic [6:0]    bit_cnt;
  logic [NW-1:0] blk_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prbs_block_ctrl #(
    .BLOCK_BITS(BB),
    .NBLK_W(NW)
`ifdef PRBS_STALL_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .prbs_load(prbs_load), .prbs_en(prbs_en),
    .prbs_valid(prbs_valid), .prbs_ready(prbs_ready), .fec_ready(fec_ready), .busy(busy),
    .block_start(block_start), .block_end(block_end), .done(done), .bit_cnt(bit_cnt),
    .blk_cnt(blk_cnt), .err(err)
  );

  typedef struct { int b; int k; } xf_t;
  xf_t exp_q[$];
  xf_t mon_e;

  typedef struct {
    logic pr, fr, sv, ex_rdy, ex_en;
    int   reps;
  } vec_t;
  vec_t vec[7];

  int n_load, n_en, n_done, cyc, end_cyc;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_frame(input int nb);
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < BB; i++)
        exp_q.push_back('{i, b});
  endtask

  task automatic go(input int nb, input bit push);
    n_load = 0; n_en = 0; n_done = 0;
    if (push) push_frame(nb);
    num_blocks = nb[NW-1:0];
    start = 1'b1;
    nxt();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input int exp_blk);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      smp();
      if (done) begin
        seen = 1'b1;
        chk({name, "_done_blk_cnt"}, blk_cnt, exp_blk);
        chk({name, "_done_src_ready"}, src_ready, 0);
        chk({name, "_done_busy"}, busy, 1);
      end
      nxt();
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  // Scoreboard: every observed transfer must match the next expected (bit, block) pair.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("valid_eq_en", prbs_valid, prbs_en);
      if (prbs_load) begin
        n_load++;
        chk("load_no_xfer", prbs_en, 0);
        chk("load_on_boundary", n_en % BB, 0);
      end
      if (prbs_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_xfer: bit_cnt=%0d blk_cnt=%0d with no transfer expected", bit_cnt, blk_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer_bit_cnt", bit_cnt, mon_e.b);
          chk("xfer_blk_cnt", blk_cnt, mon_e.k);
          chk("block_start", block_start, int'(mon_e.b == 0));
          chk("block_end", block_end, int'(mon_e.b == BB - 1));
        end
        n_en++;
        if (block_end) end_cyc = cyc;
      end else begin
        chk("start_end_no_xfer", {block_start, block_end}, 0);
      end
      if (done) begin
        n_done++;
        chk("done_after_end", cyc - end_cyc, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  bitx;
    bit  found;

    //               pr    fr    sv    rdy   en   reps
    vec[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10};
    vec[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3};
    vec[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vec[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vec[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5};
    vec[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vec[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};

    // Reset with start and valid asserted: reset must win.
    reset = 1'b1; start = 1'b1; abort = 1'b0; src_valid = 1'b1;
    prbs_ready = 1'b1; fec_ready = 1'b1; num_blocks = 8'd1;
    n_load = 0; n_en = 0; n_done = 0; cyc = 0; end_cyc = 0;
    nxt(); nxt(); smp();
    chk("rst_busy", busy, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_prbs_load", prbs_load, 0);
    chk("rst_prbs_en", prbs_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    nxt();
    reset = 1'b0; start = 1'b0; src_valid = 1'b0;
    nxt();

    // Single block, continuous valid.
    src_valid = 1'b1;
    go(1, 1'b1);
    smp();
    chk("t1_load", prbs_load, 1);
    chk("t1_load_src_ready", src_ready, 0);
    chk("t1_load_busy", busy, 1);
    chk("t1_load_bit_cnt", bit_cnt, 0);
    nxt();
    for (int i = 0; i < BB; i++) begin
      smp();
      chk($sformatf("t1_en_bit%0d", i), prbs_en, 1);
      nxt();
    end
    smp();
    chk("t1_done", done, 1);
    chk("t1_done_blk_cnt", blk_cnt, 1);
    nxt();
    smp();
    chk("t1_idle_busy", busy, 0);
    chk("t1_blk_hold", blk_cnt, 1);
    chk("t1_n_load", n_load, 1);
    chk("t1_n_en", n_en, BB);
    chk("t1_n_done", n_done, 1);
    chk("t1_q_empty", exp_q.size(), 0);
    nxt();

    // Three blocks.
    go(3, 1'b1);
    wait_done("t2", 400, 3);
    chk("t2_n_load", n_load, 3);
    chk("t2_n_en", n_en, 3 * BB);
    chk("t2_n_done", n_done, 1);
    chk("t2_q_empty", exp_q.size(), 0);
    smp();
    chk("t2_blk_hold", blk_cnt, 3);
    chk("t2_idle_busy", busy, 0);
    nxt();

    // Backpressure and source gaps from bit 40.
    go(1, 1'b1);
    nxt();
    repeat (40) nxt();
    bitx = 40;
    for (int v = 0; v < 7; v++) begin
      for (int r = 0; r < vec[v].reps; r++) begin
        prbs_ready = vec[v].pr; fec_ready = vec[v].fr; src_valid = vec[v].sv;
        smp();
        chk($sformatf("v%0d_src_ready", v), src_ready, vec[v].ex_rdy);
        chk($sformatf("v%0d_prbs_en", v), prbs_en, vec[v].ex_en);
        chk($sformatf("v%0d_bit_cnt", v), bit_cnt, bitx);
        chk($sformatf("v%0d_busy", v), busy, 1);
        if (vec[v].ex_en) bitx++;
        nxt();
      end
    end
    prbs_ready = 1'b1; fec_ready = 1'b1; src_valid = 1'b1;
    wait_done("t3", 200, 1);
    chk("t3_n_en", n_en, BB);
    chk("t3_n_load", n_load, 1);
    chk("t3_q_empty", exp_q.size(), 0);

    // Abort at bit 50 of block 2 of 4, in the same cycle as a transfer.
    go(4, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (blk_cnt == 8'd1 && bit_cnt == 7'd50) begin
        found = 1'b1;
        abort = 1'b1;
      end
      smp();
      if (found) begin
        chk("t4_abort_xfer", prbs_en, 1);
        chk("t4_abort_busy", busy, 1);
      end
      nxt();
    end
    abort = 1'b0;
    exp_q.delete();
    if (!found) begin
      total++; bad++;
      $display("FAIL t4_reach_bit50: position never reached");
    end
    smp();
    chk("t4_busy", busy, 0);
    chk("t4_bit_cnt", bit_cnt, 0);
    chk("t4_blk_cnt", blk_cnt, 0);
    chk("t4_done", done, 0);
    chk("t4_src_ready", src_ready, 0);
    nxt();
    repeat (3) nxt();
    chk("t4_n_done", n_done, 0);
    go(2, 1'b1);
    smp();
    chk("t4b_load", prbs_load, 1);
    nxt();
    wait_done("t4b", 400, 2);
    chk("t4b_n_en", n_en, 2 * BB);
    chk("t4b_n_load", n_load, 2);

    // Ignored starts: zero blocks, start with abort, start mid-frame.
    go(0, 1'b0);
    smp();
    chk("t5_zero_busy", busy, 0);
    chk("t5_zero_load", prbs_load, 0);
    chk("t5_zero_blk_hold", blk_cnt, 2);
    nxt();
    abort = 1'b1;
    go(1, 1'b0);
    abort = 1'b0;
    smp();
    chk("t5_abort_start_busy", busy, 0);
    chk("t5_abort_start_load", prbs_load, 0);
    nxt();
    repeat (2) nxt();
    chk("t5_no_done", n_done, 0);
    go(1, 1'b1);
    repeat (20) nxt();
    num_blocks = 8'd5; start = 1'b1;
    smp();
    chk("t5_mid_busy", busy, 1);
    nxt();
    start = 1'b0;
    smp();
    chk("t5_mid_bit_cnt", bit_cnt, 20);
    chk("t5_mid_load", prbs_load, 0);
    nxt();
    wait_done("t5", 200, 1);
    chk("t5_n_load", n_load, 1);
    chk("t5_n_en", n_en, BB);

    // Stall in RUN with no source data.
    src_valid = 1'b0;
`ifdef PRBS_STALL_TIMEOUT_EN
    go(1, 1'b0);
    nxt();
    for (int k = 1; k <= 16; k++) begin
      smp();
      chk($sformatf("t6_err_c%0d", k), err, int'(k == 16));
      chk($sformatf("t6_busy_c%0d", k), busy, 1);
      nxt();
    end
    smp();
    chk("t6_after_busy", busy, 0);
    chk("t6_after_err", err, 0);
    chk("t6_after_bit_cnt", bit_cnt, 0);
    nxt();
    chk("t6_no_done", n_done, 0);
`else
    go(1, 1'b0);
    nxt();
    for (int k = 1; k <= 40; k++) begin
      smp();
      chk($sformatf("t6_err_c%0d", k), err, 0);
      chk($sformatf("t6_busy_c%0d", k), busy, 1);
      nxt();
    end
    abort = 1'b1;
    nxt();
    abort = 1'b0;
    smp();
    chk("t6_abort_busy", busy, 0);
    nxt();
    chk("t6_no_done", n_done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
